ram_seq_master: RTL and testbench
=================================

# ram_seq_master

Command-driven initiator that sequences accesses to the 32 x 8 single-port RAM: write port (`wena`, `addr`, `data_in`) sampled on the rising clock edge, and combinational read of `data_out` while `wena` is low. It accepts one command at a time over a valid/ready handshake and supports three operations: fill a region, copy a region, or compute an 8-bit sum over a region. It sits between control logic and the RAM and is the only driver of the RAM's input ports.

## Interface
- `ADDR_W`, 5, RAM address width (depth 2^ADDR_W = 32).
- `DATA_W`, 8, RAM data width.
- `clk`  in  1  clock; all state changes on the rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `cmd_valid`  in  1  command present.
- `cmd_ready`  out  1  block idle, command accepted on `cmd_valid && cmd_ready`.
- `cmd_op`  in  2  0 = fill, 1 = copy, 2 = sum, 3 = illegal.
- `cmd_src`  in  ADDR_W  source start address (copy, sum).
- `cmd_dst`  in  ADDR_W  destination start address (fill, copy).
- `cmd_len`  in  6  byte count, 0..32 legal.
- `cmd_pattern`  in  DATA_W  fill byte.
- `busy`  out  1  equals `!cmd_ready`.
- `done`  out  1  one-cycle completion pulse.
- `err`  out  1  valid with `done`; 1 = rejected command.
- `result`  out  DATA_W  sum result; held until the next accept.
- `mem_wena`  out  1  to RAM `wena`.
- `mem_addr`  out  ADDR_W  to RAM `addr`.
- `mem_wdata`  out  DATA_W  to RAM `data_in`.
- `mem_rdata`  in  DATA_W  from RAM `data_out`.

## Operation
- The FSM has six states: IDLE, FILL, CP_RD, CP_WR, SUM, FIN. `cmd_ready` = 1 only in IDLE.
- On accept, the block latches op, src, dst, len and pattern, and clears the index `i`.
  - op = 3 or len > 32: go to FIN with `err` = 1. No memory access.
  - len = 0: go to FIN with `err` = 0. No memory access.
- All addresses are computed as (base + i) mod 32, so every access wraps at the top of the RAM.
- FILL: one cycle per byte. Drive `mem_wena` = 1, `mem_addr` = dst + i, `mem_wdata` = pattern. Go to FIN after i = len-1.
- CP_RD: drive `mem_wena` = 0 and `mem_addr` = src + i. At the end of the cycle, capture `mem_rdata` into a byte buffer.
  - Forwarding: if src + i equals the address written in the immediately preceding CP_WR cycle, capture the last written byte instead of `mem_rdata`. The RAM output does not refresh when the address is unchanged.
- CP_WR: drive `mem_wena` = 1, `mem_addr` = dst + i, `mem_wdata` = buffer. Then go to CP_RD with i+1, or to FIN after the last byte.
- Copy runs strictly in forward order. Overlapping regions produce the forward-order result; no memmove semantics.
- SUM: one cycle per byte. Drive `mem_wena` = 0 and `mem_addr` = src + i. The accumulator adds `mem_rdata` at the end of each cycle; the addition is 8-bit and wraps mod 256.
- FIN: pulse `done` for one cycle, drive `err`, and update `result` (sum op only; other ops leave it unchanged). Return to IDLE.
- Outside FILL and CP_WR, `mem_wena` = 0, `mem_wdata` = 0, and `mem_addr` = 0 except during read states.

## Timing
- Reset values: `cmd_ready` = 1, `busy` = 0, `done` = 0, `err` = 0, `result` = 0, `mem_wena` = 0, `mem_addr` = 0, `mem_wdata` = 0. The accumulator, index and FSM state are cleared and the FSM returns to IDLE.
- Accept at edge E0. The first memory cycle is the cycle following E0.
- Fill of N bytes: N write cycles, `done` in cycle N+1.
- Copy of N bytes: 2N cycles (RD,WR alternating), `done` in cycle 2N+1.
- Sum of N bytes: N read cycles, `done` and the new `result` in cycle N+1.
- Error or len = 0: `done` in cycle 1 after accept.
- `cmd_ready` returns to 1 in the cycle after `done`. Back-to-back commands therefore have a minimum gap of one IDLE cycle.
- Changes to `cmd_*` while busy are ignored.
- `rst` asserted mid-operation: at the next edge all outputs take their reset values, the partial operation is abandoned (bytes already written stay written), and no `done` is issued.
- `rst` and `cmd_valid` in the same cycle: reset wins and the command is not accepted.

## Test plan
- Fill dst = 30, len = 4, pattern = 0xA5: `mem_wena` is high for 4 cycles at addresses 30, 31, 0, 1. `done` = 1 with `err` = 0 in cycle 5. A subsequent sum src = 30, len = 4 gives `result` = 0x94.
- Preload mem[0..7] = 1..8. Copy src = 0, dst = 16, len = 8: mem[16..23] = 1..8 and `done` in cycle 17. Then sum src = 16, len = 8 gives `result` = 0x24.
- Preload mem[4..7] = 1, 2, 3, 4. Copy src = 4, dst = 5, len = 3: mem[5..7] = 1, 1, 1. This exercises the forwarding path.
- Fill all 32 bytes with 0xFF, then sum src = 0, len = 32: `result` = 0xE0 (wrap mod 256) and `done` in cycle 33.
- Check each rejected or empty command:
  - op = 3: `done` and `err` = 1 one cycle after accept, `mem_wena` never high, `result` unchanged.
  - len = 33: same response as op = 3.
  - len = 0: `done` with `err` = 0.
- Assert `rst` during cycle 5 of a len = 8 copy: the next cycle shows `cmd_ready` = 1 and `mem_wena` = 0, no `done` is issued, and a new fill is accepted and completes normally.

Source files
------------

// File: rtl/ram_seq_master.sv
// ----------------------------------------------------------------------------
// ram_seq_master
//
// Command-driven initiator for a 2^ADDR_W x DATA_W single-port RAM whose write
// port is sampled on the rising edge and whose read data is combinational
// while the write enable is low. One command is accepted at a time over a
// valid/ready handshake and is executed as one of:
//   fill : write a pattern byte over a region
//   copy : forward-order byte copy, alternating read and write cycles
//   sum  : 8-bit wrapping sum over a region
// All region addresses wrap modulo the RAM depth.
//
// Ports
//   clk_i          clock, all state changes on the rising edge
//   rst_i          synchronous active-high reset
//   cmd_valid_i    command present
//   cmd_ready_o    idle, command accepted on cmd_valid_i && cmd_ready_o
//   cmd_op_i       0 fill, 1 copy, 2 sum, 3 illegal
//   cmd_src_i      source start address (copy, sum)
//   cmd_dst_i      destination start address (fill, copy)
//   cmd_len_i      byte count, 0..2^ADDR_W legal
//   cmd_pattern_i  fill byte
//   busy_o         inverse of cmd_ready_o
//   done_o         one-cycle completion pulse
//   err_o          valid with done_o, 1 = command rejected
//   result_o       sum result, held until a later sum completes
//   mem_wena_o     RAM write enable
//   mem_addr_o     RAM address
//   mem_wdata_o    RAM write data
//   mem_rdata_i    RAM read data
//
// Every output is a flop; the next output values are decoded from the
// next-state values so the RAM sees a clean address/enable for the whole cycle
// that the state register says it belongs to.
// ----------------------------------------------------------------------------
module ram_seq_master #(
    parameter int ADDR_W = 5,
    parameter int DATA_W = 8
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              cmd_valid_i,
    output logic              cmd_ready_o,
    input  logic [1:0]        cmd_op_i,
    input  logic [ADDR_W-1:0] cmd_src_i,
    input  logic [ADDR_W-1:0] cmd_dst_i,
    input  logic [ADDR_W:0]   cmd_len_i,
    input  logic [DATA_W-1:0] cmd_pattern_i,
    output logic              busy_o,
    output logic              done_o,
    output logic              err_o,
    output logic [DATA_W-1:0] result_o,
    output logic              mem_wena_o,
    output logic [ADDR_W-1:0] mem_addr_o,
    output logic [DATA_W-1:0] mem_wdata_o,
    input  logic [DATA_W-1:0] mem_rdata_i
);

    // Length/index counters need one extra bit so that a full-depth length
    // is representable.
    localparam int LEN_W = ADDR_W + 1;

    localparam logic [1:0]        OP_FILL   = 2'd0;
    localparam logic [1:0]        OP_COPY   = 2'd1;
    localparam logic [1:0]        OP_SUM    = 2'd2;
    localparam logic [1:0]        OP_ILL    = 2'd3;

    localparam logic [LEN_W-1:0]  MAX_LEN   = {1'b1, {ADDR_W{1'b0}}};
    localparam logic [LEN_W-1:0]  LEN_ZERO  = {LEN_W{1'b0}};
    localparam logic [LEN_W-1:0]  LEN_ONE   = {{ADDR_W{1'b0}}, 1'b1};
    localparam logic [ADDR_W-1:0] ADDR_ZERO = {ADDR_W{1'b0}};
    localparam logic [DATA_W-1:0] DATA_ZERO = {DATA_W{1'b0}};

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_FILL  = 3'd1,
        ST_CP_RD = 3'd2,
        ST_CP_WR = 3'd3,
        ST_SUM   = 3'd4,
        ST_FIN   = 3'd5
    } state_e;

    // Region address: base plus byte index, wrapping at the top of the RAM.
    function automatic logic [ADDR_W-1:0] wrap_addr(
        input logic [ADDR_W-1:0] base,
        input logic [LEN_W-1:0]  idx
    );
        return base + idx[ADDR_W-1:0];
    endfunction

    // ------------------------------------------------------------------
    // Control and datapath registers
    // ------------------------------------------------------------------
    state_e              state_q,   state_d;
    logic [1:0]          op_q,      op_d;
    logic [ADDR_W-1:0]   src_q,     src_d;
    logic [ADDR_W-1:0]   dst_q,     dst_d;
    logic [LEN_W-1:0]    len_q,     len_d;
    logic [DATA_W-1:0]   pat_q,     pat_d;
    logic [LEN_W-1:0]    idx_q,     idx_d;
    logic [DATA_W-1:0]   buf_q,     buf_d;
    logic [DATA_W-1:0]   acc_q,     acc_d;
    logic                rej_q,     rej_d;
    // Address written in the previous cycle, valid only right after CP_WR.
    logic                wr_prev_q, wr_prev_d;
    logic [ADDR_W-1:0]   wr_addr_q, wr_addr_d;

    // Output registers
    logic                ready_q,   ready_d;
    logic                busy_q,    busy_d;
    logic                done_q,    done_d;
    logic                err_q,     err_d;
    logic [DATA_W-1:0]   result_q,  result_d;
    logic                wena_q,    wena_d;
    logic [ADDR_W-1:0]   addr_q,    addr_d;
    logic [DATA_W-1:0]   wdata_q,   wdata_d;

    logic                last_byte_s;
    logic                fwd_hit_s;

    // Next-state, index, copy buffer and accumulator logic.
    always_comb begin
        state_d   = state_q;
        op_d      = op_q;
        src_d     = src_q;
        dst_d     = dst_q;
        len_d     = len_q;
        pat_d     = pat_q;
        idx_d     = idx_q;
        buf_d     = buf_q;
        acc_d     = acc_q;
        rej_d     = rej_q;
        wr_prev_d = 1'b0;
        wr_addr_d = wr_addr_q;

        last_byte_s = (idx_q == (len_q - LEN_ONE));
        // The RAM read data does not refresh when the address is unchanged
        // after a write, so a read of the byte just written must come from
        // the copy buffer, which still holds that byte.
        fwd_hit_s   = wr_prev_q && (wrap_addr(src_q, idx_q) == wr_addr_q);

        case (state_q)
            ST_IDLE: begin
                if (cmd_valid_i) begin
                    op_d  = cmd_op_i;
                    src_d = cmd_src_i;
                    dst_d = cmd_dst_i;
                    len_d = cmd_len_i;
                    pat_d = cmd_pattern_i;
                    idx_d = LEN_ZERO;
                    acc_d = DATA_ZERO;
                    if ((cmd_op_i == OP_ILL) || (cmd_len_i > MAX_LEN)) begin
                        rej_d   = 1'b1;
                        state_d = ST_FIN;
                    end else if (cmd_len_i == LEN_ZERO) begin
                        rej_d   = 1'b0;
                        state_d = ST_FIN;
                    end else begin
                        rej_d = 1'b0;
                        case (cmd_op_i)
                            OP_FILL: state_d = ST_FILL;
                            OP_COPY: state_d = ST_CP_RD;
                            default: state_d = ST_SUM;
                        endcase
                    end
                end else begin
                    state_d = ST_IDLE;
                end
            end

            ST_FILL: begin
                if (last_byte_s) begin
                    state_d = ST_FIN;
                end else begin
                    idx_d   = idx_q + LEN_ONE;
                    state_d = ST_FILL;
                end
            end

            ST_CP_RD: begin
                buf_d   = fwd_hit_s ? buf_q : mem_rdata_i;
                state_d = ST_CP_WR;
            end

            ST_CP_WR: begin
                wr_prev_d = 1'b1;
                wr_addr_d = wrap_addr(dst_q, idx_q);
                if (last_byte_s) begin
                    state_d = ST_FIN;
                end else begin
                    idx_d   = idx_q + LEN_ONE;
                    state_d = ST_CP_RD;
                end
            end

            ST_SUM: begin
                acc_d = acc_q + mem_rdata_i;
                if (last_byte_s) begin
                    state_d = ST_FIN;
                end else begin
                    idx_d   = idx_q + LEN_ONE;
                    state_d = ST_SUM;
                end
            end

            ST_FIN: begin
                state_d = ST_IDLE;
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Next output values, decoded from the state being entered.
    always_comb begin
        ready_d  = 1'b0;
        busy_d   = 1'b1;
        done_d   = 1'b0;
        err_d    = 1'b0;
        result_d = result_q;
        wena_d   = 1'b0;
        addr_d   = ADDR_ZERO;
        wdata_d  = DATA_ZERO;

        case (state_d)
            ST_IDLE: begin
                ready_d = 1'b1;
                busy_d  = 1'b0;
            end
            ST_FILL: begin
                wena_d  = 1'b1;
                addr_d  = wrap_addr(dst_d, idx_d);
                wdata_d = pat_d;
            end
            ST_CP_RD: begin
                addr_d = wrap_addr(src_d, idx_d);
            end
            ST_CP_WR: begin
                wena_d  = 1'b1;
                addr_d  = wrap_addr(dst_d, idx_d);
                wdata_d = buf_d;
            end
            ST_SUM: begin
                addr_d = wrap_addr(src_d, idx_d);
            end
            ST_FIN: begin
                done_d = 1'b1;
                err_d  = rej_d;
                // Only an accepted sum publishes a new result; a zero-length
                // sum publishes zero.
                if ((op_d == OP_SUM) && !rej_d) begin
                    result_d = acc_d;
                end else begin
                    result_d = result_q;
                end
            end
            default: begin
                ready_d = 1'b1;
                busy_d  = 1'b0;
            end
        endcase
    end

    // State, datapath and output registers with synchronous reset.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q   <= ST_IDLE;
            op_q      <= 2'd0;
            src_q     <= ADDR_ZERO;
            dst_q     <= ADDR_ZERO;
            len_q     <= LEN_ZERO;
            pat_q     <= DATA_ZERO;
            idx_q     <= LEN_ZERO;
            buf_q     <= DATA_ZERO;
            acc_q     <= DATA_ZERO;
            rej_q     <= 1'b0;
            wr_prev_q <= 1'b0;
            wr_addr_q <= ADDR_ZERO;
            ready_q   <= 1'b1;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            err_q     <= 1'b0;
            result_q  <= DATA_ZERO;
            wena_q    <= 1'b0;
            addr_q    <= ADDR_ZERO;
            wdata_q   <= DATA_ZERO;
        end else begin
            state_q   <= state_d;
            op_q      <= op_d;
            src_q     <= src_d;
            dst_q     <= dst_d;
            len_q     <= len_d;
            pat_q     <= pat_d;
            idx_q     <= idx_d;
            buf_q     <= buf_d;
            acc_q     <= acc_d;
            rej_q     <= rej_d;
            wr_prev_q <= wr_prev_d;
            wr_addr_q <= wr_addr_d;
            ready_q   <= ready_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
            err_q     <= err_d;
            result_q  <= result_d;
            wena_q    <= wena_d;
            addr_q    <= addr_d;
            wdata_q   <= wdata_d;
        end
    end

    assign cmd_ready_o = ready_q;
    assign busy_o      = busy_q;
    assign done_o      = done_q;
    assign err_o       = err_q;
    assign result_o    = result_q;
    assign mem_wena_o  = wena_q;
    assign mem_addr_o  = addr_q;
    assign mem_wdata_o = wdata_q;

endmodule

// File: tb/tb_ram_seq_master.sv
// ----------------------------------------------------------------------------
// Bench for ram_seq_master. A 32 x 8 RAM model (with the stale read-after-write
// output behaviour of the real RAM) is attached to the memory port. For each
// accepted command the bench builds the full expected cycle-by-cycle output
// trace from a plain array model of memory, and one compare process checks
// every cycle against that trace (or against idle outputs when no command is
// in flight). A few literal results pin the model itself.
// ----------------------------------------------------------------------------
module tb_ram_seq_master;

    localparam int AW = 5;
    localparam int DW = 8;

    logic          clk = 1'b0;
    logic          rst;
    logic          cmd_valid;
    logic          cmd_ready;
    logic [1:0]    cmd_op;
    logic [AW-1:0] cmd_src;
    logic [AW-1:0] cmd_dst;
    logic [AW:0]   cmd_len;
    logic [DW-1:0] cmd_pattern;
    logic          busy;
    logic          done;
    logic          err;
    logic [DW-1:0] result;
    logic          mem_wena;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata;
    logic [DW-1:0] mem_rdata;

    always #5 clk = ~clk;

    ram_seq_master #(.ADDR_W(AW), .DATA_W(DW)) dut (
        .clk_i        (clk),
        .rst_i        (rst),
        .cmd_valid_i  (cmd_valid),
        .cmd_ready_o  (cmd_ready),
        .cmd_op_i     (cmd_op),
        .cmd_src_i    (cmd_src),
        .cmd_dst_i    (cmd_dst),
        .cmd_len_i    (cmd_len),
        .cmd_pattern_i(cmd_pattern),
        .busy_o       (busy),
        .done_o       (done),
        .err_o        (err),
        .result_o     (result),
        .mem_wena_o   (mem_wena),
        .mem_addr_o   (mem_addr),
        .mem_wdata_o  (mem_wdata),
        .mem_rdata_i  (mem_rdata)
    );

    // ---------------- RAM attached to the DUT ----------------
    logic [DW-1:0] ram [32] = '{default: 8'h00};
    logic          prev_w   = 1'b0;
    logic [AW-1:0] prev_a   = 5'd0;
    logic [DW-1:0] prev_old = 8'h00;

    always @(posedge clk) begin
        if (mem_wena === 1'b1) begin
            prev_old      <= ram[mem_addr];
            ram[mem_addr] <= mem_wdata;
            prev_w        <= 1'b1;
            prev_a        <= mem_addr;
        end else begin
            prev_w <= 1'b0;
        end
    end

    // Reading the address just written, with wena now low, returns stale data.
    always_comb begin
        if (!mem_wena && prev_w && (prev_a == mem_addr)) mem_rdata = prev_old;
        else                                             mem_rdata = ram[mem_addr];
    end

    // ---------------- reference model ----------------
    typedef struct packed {
        logic          wena;
        logic [AW-1:0] addr;
        logic [DW-1:0] wdata;
        logic          ready;
        logic          done;
        logic          err;
        logic [DW-1:0] result;
    } exp_t;

    exp_t          exp_q[$];
    logic [DW-1:0] mdl [32] = '{default: 8'h00};
    logic [DW-1:0] model_result = 8'h00;
    int            n_chk  = 0;
    int            n_fail = 0;
    logic          chk_en = 1'b0;
    exp_t          cmp_e;
    exp_t          cmp_g;

    function automatic exp_t mk(input logic w, input logic [AW-1:0] a, input logic [DW-1:0] d,
                                input logic rdy, input logic dn, input logic er, input logic [DW-1:0] res);
        exp_t e;
        e.wena = w; e.addr = a; e.wdata = d; e.ready = rdy; e.done = dn; e.err = er; e.result = res;
        return e;
    endfunction

    // Expected trace for one accepted command, from the operation's rules.
    task automatic push_cmd(input int op, input int src, input int dst, input int len, input logic [DW-1:0] pat);
        logic [DW-1:0] tmp [32];
        logic [DW-1:0] b;
        logic [DW-1:0] acc;
        int            a;
        tmp = mdl;
        acc = 8'h00;
        if (op == 3 || len > 32) begin
            exp_q.push_back(mk(1'b0, 5'd0, 8'h00, 1'b0, 1'b1, 1'b1, model_result));
        end else begin
            for (int k = 0; k < len; k++) begin
                if (op == 0) begin
                    a = (dst + k) % 32;
                    tmp[a] = pat;
                    exp_q.push_back(mk(1'b1, a[AW-1:0], pat, 1'b0, 1'b0, 1'b0, model_result));
                end else if (op == 1) begin
                    a = (src + k) % 32;
                    b = tmp[a];
                    exp_q.push_back(mk(1'b0, a[AW-1:0], 8'h00, 1'b0, 1'b0, 1'b0, model_result));
                    a = (dst + k) % 32;
                    tmp[a] = b;
                    exp_q.push_back(mk(1'b1, a[AW-1:0], b, 1'b0, 1'b0, 1'b0, model_result));
                end else begin
                    a = (src + k) % 32;
                    acc = acc + tmp[a];
                    exp_q.push_back(mk(1'b0, a[AW-1:0], 8'h00, 1'b0, 1'b0, 1'b0, model_result));
                end
            end
            if (op == 2) model_result = acc;
            exp_q.push_back(mk(1'b0, 5'd0, 8'h00, 1'b0, 1'b1, 1'b0, model_result));
        end
    endtask

    // Per-cycle output check against the trace, or idle outputs.
    always @(negedge clk) begin
        if (chk_en) begin
            if (exp_q.size() != 0) cmp_e = exp_q.pop_front();
            else                   cmp_e = mk(1'b0, 5'd0, 8'h00, 1'b1, 1'b0, 1'b0, model_result);
            cmp_g = mk(mem_wena, mem_addr, mem_wdata, cmd_ready, done, err, result);
            if (cmp_e.wena) mdl[cmp_e.addr] = cmp_e.wdata;
            n_chk++;
            if ((cmp_g !== cmp_e) || (busy !== ~cmp_e.ready)) begin
                n_fail++;
                $display("FAIL cycle_outputs t=%0t: got wena=%b addr=%0d wdata=%h ready=%b busy=%b done=%b err=%b result=%h ; expected wena=%b addr=%0d wdata=%h ready=%b busy=%b done=%b err=%b result=%h",
                         $time, cmp_g.wena, cmp_g.addr, cmp_g.wdata, cmp_g.ready, busy, cmp_g.done, cmp_g.err, cmp_g.result,
                         cmp_e.wena, cmp_e.addr, cmp_e.wdata, cmp_e.ready, ~cmp_e.ready, cmp_e.done, cmp_e.err, cmp_e.result);
            end
        end
    end

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] expv);
        n_chk++;
        if (got !== expv) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, got, expv);
        end
    endtask

    task automatic wait_idle();
        int t;
        t = 0;
        while (exp_q.size() != 0 && t < 200) begin
            @(negedge clk); #1;
            t++;
        end
        if (exp_q.size() != 0) begin
            n_chk++;
            n_fail++;
            $display("FAIL wait_idle: %0d expected cycles still pending, required 0", exp_q.size());
            exp_q.delete();
        end
    endtask

    task automatic issue(input int op, input int src, input int dst, input int len, input logic [DW-1:0] pat);
        wait_idle();
        @(negedge clk); #1;
        cmd_valid   = 1'b1;
        cmd_op      = op[1:0];
        cmd_src     = src[AW-1:0];
        cmd_dst     = dst[AW-1:0];
        cmd_len     = len[AW:0];
        cmd_pattern = pat;
        @(posedge clk); #1;
        cmd_valid   = 1'b0;
        // Command fields wander while busy; they must be ignored.
        cmd_op      = 2'($urandom);
        cmd_src     = 5'($urandom);
        cmd_dst     = 5'($urandom);
        cmd_len     = 6'($urandom);
        cmd_pattern = 8'($urandom);
        push_cmd(op, src, dst, len, pat);
    endtask

    initial begin
        rst = 1'b1; cmd_valid = 1'b0; cmd_op = 2'd0; cmd_src = 5'd0; cmd_dst = 5'd0;
        cmd_len = 6'd0; cmd_pattern = 8'h00;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        chk("reset_state", 32'({cmd_ready, busy, done, err, result, mem_wena, mem_addr, mem_wdata}),
            32'({1'b1, 1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 5'd0, 8'h00}));
        chk_en = 1'b1;

        // Wrapping fill and sum.
        issue(0, 0, 30, 4, 8'hA5);
        issue(2, 30, 0, 4, 8'h00);
        wait_idle();
        chk("fill_wrap_ram0", 32'(ram[0]), 32'h0000_00A5);
        chk("sum_after_fill_dut", 32'(result), 32'h0000_0094);
        chk("sum_after_fill_model", 32'(model_result), 32'h0000_0094);

        // Copy 0..7 -> 16..23.
        for (int k = 0; k < 8; k++) issue(0, 0, k, 1, 8'(k + 1));
        issue(1, 0, 16, 8, 8'h00);
        issue(2, 16, 0, 8, 8'h00);
        wait_idle();
        chk("copy_ram23", 32'(ram[23]), 32'h0000_0008);
        chk("sum_after_copy_dut", 32'(result), 32'h0000_0024);
        chk("sum_after_copy_model", 32'(model_result), 32'h0000_0024);

        // Overlapping forward copy that needs read-after-write forwarding.
        for (int k = 0; k < 4; k++) issue(0, 0, 4 + k, 1, 8'(k + 1));
        issue(1, 4, 5, 3, 8'h00);
        wait_idle();
        chk("overlap_ram5_7", 32'({ram[5], ram[6], ram[7]}), 32'h0001_0101);
        chk("overlap_mdl5_7", 32'({mdl[5], mdl[6], mdl[7]}), 32'h0001_0101);

        // Full-depth fill and sum.
        issue(0, 0, 0, 32, 8'hFF);
        issue(2, 0, 0, 32, 8'h00);
        wait_idle();
        chk("sum_full_dut", 32'(result), 32'h0000_00E0);
        chk("sum_full_model", 32'(model_result), 32'h0000_00E0);

        // Rejected and empty commands.
        issue(3, 0, 0, 5, 8'h11);
        issue(0, 0, 0, 33, 8'h22);
        issue(2, 0, 0, 40, 8'h00);
        issue(1, 3, 9, 0, 8'h00);
        wait_idle();
        chk("result_kept_after_rejects", 32'(result), 32'h0000_00E0);

        // Reset and valid together: reset wins, nothing accepted.
        @(negedge clk); #1;
        rst = 1'b1; cmd_valid = 1'b1; cmd_op = 2'd0; cmd_dst = 5'd9; cmd_len = 6'd4; cmd_pattern = 8'h5A;
        @(posedge clk); #1;
        rst = 1'b0; cmd_valid = 1'b0;
        model_result = 8'h00;
        repeat (2) @(negedge clk);
        #1;

        // Reset in cycle 5 of an 8-byte copy.
        issue(1, 0, 16, 8, 8'h00);
        repeat (4) @(posedge clk);
        #1 rst = 1'b1;
        while (exp_q.size() > 1) exp_q.delete(exp_q.size() - 1);
        model_result = 8'h00;
        @(posedge clk); #1;
        rst = 1'b0;
        chk("midop_reset_outputs", 32'({cmd_ready, mem_wena, done}), 32'h0000_0004);
        repeat (3) @(negedge clk);
        #1;
        issue(0, 0, 3, 2, 8'h3C);
        wait_idle();
        chk("fill_after_reset", 32'({ram[3], ram[4]}), 32'h0000_3C3C);

        // Randomized commands.
        for (int n = 0; n < 40; n++) begin
            int op, len;
            op  = $urandom_range(0, 3);
            len = ($urandom_range(0, 7) == 0) ? $urandom_range(33, 63) : $urandom_range(0, 32);
            if (op == 3 && $urandom_range(0, 1) == 0) op = 2;
            issue(op, $urandom_range(0, 31), $urandom_range(0, 31), len, 8'($urandom));
        end
        wait_idle();
        repeat (3) @(negedge clk);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
